exec_wb_buffer: RTL

//  Registered execute->writeback boundary: captures each ALU result (rotate, shift, add...)

---
 rtl/exec_wb_buffer_pkg.sv | 51 +++++
 rtl/exec_wb_buffer_slot.sv | 47 ++++
 rtl/exec_wb_buffer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/exec_wb_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exec_wb_buffer_pkg
//  Description : Shared widths, flag bit positions, the buffered entry record
//                and the flag-forwarding selection helper for the
//                execute->writeback boundary buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package exec_wb_buffer_pkg;

    // Datapath widths
    localparam int W_OPR      = 32;
    localparam int W_FLAGS    = 4;
    localparam int W_REG_ADDR = 5;

    // Flag vector layout: {overflow, sign, zero, carry}
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_V = 3;

    // One buffered ALU result on its way to writeback
    typedef struct packed {
        logic [W_OPR-1:0]      result;
        logic [W_FLAGS-1:0]    flags;
        logic [W_REG_ADDR-1:0] dst;
        logic                  we;
        logic                  setf;
    } wb_entry_t;

    // The youngest in-flight flag producer wins; with none in flight the
    // next ALU op sees the committed architectural flags.
    function automatic logic [W_FLAGS-1:0] select_fwd_flags(
        input logic                 skid_valid,
        input wb_entry_t            skid,
        input logic                 main_valid,
        input wb_entry_t            main,
        input logic [W_FLAGS-1:0]   committed
    );
        logic [W_FLAGS-1:0] sel;
        sel = committed;
        if (skid_valid && skid.setf) begin
            sel = skid.flags;
        end else if (main_valid && main.setf) begin
            sel = main.flags;
        end
        return sel;
    endfunction

endpackage : exec_wb_buffer_pkg
`default_nettype wire

// File: rtl/exec_wb_buffer_slot.sv
`default_nettype none
// ============================================================================
//  Module      : exec_wb_slot
//  Description : One storage slot of the execute->writeback buffer. Holds a
//                valid bit plus the full entry record.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                load       - capture d and mark the slot valid
//                clear      - invalidate the slot (wins over load)
//                d          - entry to capture
//                valid, q   - slot occupancy and stored entry
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_wb_slot
    import exec_wb_buffer_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  logic      clear,
    input  wb_entry_t d,
    output logic      valid,
    output wb_entry_t q
);

    logic      r_valid;
    wb_entry_t r_entry;

    // Reset zeroes the payload so the writeback outputs come up at zero.
    // Clear only drops the valid bit: the payload of an empty slot is
    // don't-care and every consumer qualifies it with valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else if (clear) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_entry <= d;
        end
    end

    assign valid = r_valid;
    assign q     = r_entry;

endmodule : exec_wb_slot
`default_nettype wire

// File: rtl/exec_wb_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : exec_wb_buffer
//  Description : Registered execute->writeback boundary. Two-entry skid
//                buffer (main = oldest, skid = second) so the upstream ready
//                is a pure flop output while one entry per cycle still flows.
//                Owns the architectural flag register, committed at retire.
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                flush_i              - discard every buffered entry
//                ex_valid_i/ex_ready_o- execute-side handshake
//                ex_result_i, ex_flags_i, ex_dst_i, ex_we_i, ex_setf_i
//                                     - entry payload from the ALU
//                wb_valid_o/wb_ready_i- writeback-side handshake
//                wb_result_o, wb_dst_o, wb_we_o
//                                     - oldest entry toward writeback
//                flags_o              - committed architectural flags
//                flags_fwd_o          - youngest in-flight flags
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_wb_buffer
    import exec_wb_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic [W_OPR-1:0]      ex_result_i,
    input  logic [W_FLAGS-1:0]    ex_flags_i,
    input  logic [W_REG_ADDR-1:0] ex_dst_i,
    input  logic                  ex_we_i,
    input  logic                  ex_setf_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [W_OPR-1:0]      wb_result_o,
    output logic [W_REG_ADDR-1:0] wb_dst_o,
    output logic                  wb_we_o,
    output logic [W_FLAGS-1:0]    flags_o,
    output logic [W_FLAGS-1:0]    flags_fwd_o
);

    // Occupancy states
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_ex_ready;
    logic [W_FLAGS-1:0] r_flags;

    wb_entry_t          w_in_entry;
    wb_entry_t          w_main_d;
    wb_entry_t          w_main_q;
    wb_entry_t          w_skid_q;
    logic               w_main_valid;
    logic               w_skid_valid;
    logic               w_main_load;
    logic               w_main_clear;
    logic               w_skid_load;
    logic               w_skid_clear;
    logic               w_accept;
    logic               w_retire;

    assign w_in_entry = '{result: ex_result_i,
                          flags:  ex_flags_i,
                          dst:    ex_dst_i,
                          we:     ex_we_i,
                          setf:   ex_setf_i};

    assign w_accept = ex_valid_i & r_ex_ready;
    assign w_retire = w_main_valid & wb_ready_i;

    // ------------------------------------------------------------------
    // Control: decide slot loads/clears and the next occupancy state.
    // The main slot always holds the oldest entry, so in TWO a retire
    // promotes skid into main; in ONE a simultaneous accept+retire just
    // overwrites main, keeping the skid slot free.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        w_main_d     = w_in_entry;

        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_main_load = 1'b1;
                    w_state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (w_accept && w_retire) begin
                    w_main_load = 1'b1;
                end else if (w_accept) begin
                    w_skid_load = 1'b1;
                    w_state_nxt = S_TWO;
                end else if (w_retire) begin
                    w_main_clear = 1'b1;
                    w_state_nxt  = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_retire) begin
                    w_main_d     = w_skid_q;
                    w_main_load  = 1'b1;
                    w_skid_clear = 1'b1;
                    w_state_nxt  = S_ONE;
                end
            end
            default: begin
                w_main_clear = 1'b1;
                w_skid_clear = 1'b1;
                w_state_nxt  = S_EMPTY;
            end
        endcase

        // A flush throws away everything, including whatever was being
        // accepted or retired in the same cycle.
        if (flush_i) begin
            w_main_load  = 1'b0;
            w_skid_load  = 1'b0;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
            w_state_nxt  = S_EMPTY;
        end
    end

    // Ready is registered alongside the state so upstream never sees a
    // combinational path from wb_ready_i.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_ex_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_ex_ready <= (w_state_nxt != S_TWO);
        end
    end

    // Architectural flags commit only when a flag-setting entry actually
    // retires; a flush in the same cycle cancels that retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= '0;
        end else if (w_retire && !flush_i && w_main_q.setf) begin
            r_flags <= w_main_q.flags;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    exec_wb_slot u_main_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (w_main_load),
        .clear (w_main_clear),
        .d     (w_main_d),
        .valid (w_main_valid),
        .q     (w_main_q)
    );

    exec_wb_slot u_skid_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (w_skid_load),
        .clear (w_skid_clear),
        .d     (w_in_entry),
        .valid (w_skid_valid),
        .q     (w_skid_q)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ex_ready_o  = r_ex_ready;
    assign wb_valid_o  = w_main_valid;
    assign wb_result_o = w_main_q.result;
    assign wb_dst_o    = w_main_q.dst;
    assign wb_we_o     = w_main_valid & w_main_q.we;
    assign flags_o     = r_flags;
    assign flags_fwd_o = select_fwd_flags(w_skid_valid, w_skid_q,
                                          w_main_valid, w_main_q, r_flags);

endmodule : exec_wb_buffer
`default_nettype wire
